// File: rtl/snake_pkg.sv
// snake_pkg: game-status encodings, mine count and grid widths
// shared by the snake game blocks.
package snake_pkg;

  typedef enum logic [1:0] {
    GS_RESTART = 2'b00,
    GS_START   = 2'b01,
    GS_PLAY    = 2'b10,
    GS_DIE     = 2'b11
  } game_status_e;

  typedef enum logic {
    SP_IDLE = 1'b0,
    SP_PICK = 1'b1
  } spawn_state_e;

  localparam int NUM_MINES   = 4;
  localparam int COL_W       = 6;
  localparam int ROW_W       = 6;
  localparam int APPLE_ROW_W = 5;

endpackage

// File: rtl/mine_lfsr.sv
// mine_lfsr: 16-bit Galois LFSR, x^16+x^14+x^13+x^11.
// Ports: clk, rst (sync, loads SEED) in; state_o (current state) out.
module mine_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ 16'hB400;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/mine_scheduler.sv
// mine_scheduler: spawns, ages, hit-checks and retires four mines.
// Ports: clk, rst, game_status, tick, head_x/y, apple_x/y in;
// mine_x_0..3, mine_y_0..3, mine_active, mine_hit out.
module mine_scheduler
  import snake_pkg::*;
#(
  parameter int          SPAWN_TICKS = 8,
  parameter int          LIFETIME    = 40,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          X_MAX       = 38,
  parameter int          Y_MAX       = 28,
  parameter int          MAX_TRIES   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             game_status,
  input  logic                   tick,
  input  logic [COL_W-1:0]       head_x,
  input  logic [ROW_W-1:0]       head_y,
  input  logic [COL_W-1:0]       apple_x,
  input  logic [APPLE_ROW_W-1:0] apple_y,
  output logic [COL_W-1:0]       mine_x_0,
  output logic [COL_W-1:0]       mine_x_1,
  output logic [COL_W-1:0]       mine_x_2,
  output logic [COL_W-1:0]       mine_x_3,
  output logic [ROW_W-1:0]       mine_y_0,
  output logic [ROW_W-1:0]       mine_y_1,
  output logic [ROW_W-1:0]       mine_y_2,
  output logic [ROW_W-1:0]       mine_y_3,
  output logic [NUM_MINES-1:0]   mine_active,
  output logic                   mine_hit
);

  localparam int AGE_W = $clog2(LIFETIME + 1);
  localparam int SPN_W = $clog2(SPAWN_TICKS + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int IDX_W = $clog2(NUM_MINES);

  logic [15:0]          lfsr;
  logic                 lfsr_unused;
  logic [COL_W-1:0]     x_q [NUM_MINES];
  logic [COL_W-1:0]     x_d [NUM_MINES];
  logic [ROW_W-1:0]     y_q [NUM_MINES];
  logic [ROW_W-1:0]     y_d [NUM_MINES];
  logic [AGE_W-1:0]     age_q [NUM_MINES];
  logic [AGE_W-1:0]     age_d [NUM_MINES];
  logic [NUM_MINES-1:0] act_q, act_d;
  logic [SPN_W-1:0]     spn_q, spn_d;
  logic [TRY_W-1:0]     try_q, try_d;
  spawn_state_e         st_q, st_d;
  logic                 hit_q, hit_d;
  logic [COL_W-1:0]     cx;
  logic [ROW_W-1:0]     cy;
  logic                 cand_ok;
  logic                 due;
  logic                 free_ok;
  logic [IDX_W-1:0]     free_idx;

  mine_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .state_o(lfsr)
  );

  assign cx = lfsr[5:0];
  assign cy = {1'b0, lfsr[10:6]};
  assign lfsr_unused = ^lfsr[15:11];

  // Candidate legality is judged against the mines shown this cycle.
  always_comb begin
    cand_ok = (cx != '0) && (cx <= COL_W'(X_MAX))
           && (cy != '0) && (cy <= ROW_W'(Y_MAX));
    if (cx == apple_x && cy == ROW_W'(apple_y)) begin
      cand_ok = 1'b0;
    end
    if (cx == head_x && cy == head_y) begin
      cand_ok = 1'b0;
    end
    for (int n = 0; n < NUM_MINES; n++) begin
      if (act_q[n] && x_q[n] == cx && y_q[n] == cy) begin
        cand_ok = 1'b0;
      end
    end
  end

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    age_d    = age_q;
    act_d    = act_q;
    spn_d    = spn_q;
    try_d    = try_q;
    st_d     = st_q;
    hit_d    = 1'b0;
    due      = 1'b0;
    free_ok  = 1'b0;
    free_idx = '0;
    unique case (1'b1)
      game_status == GS_PLAY: begin
        if (tick) begin
          for (int n = 0; n < NUM_MINES; n++) begin
            if (act_q[n]) begin
              if (x_q[n] == head_x && y_q[n] == head_y) begin
                act_d[n] = 1'b0;
                hit_d    = 1'b1;
              end
              age_d[n] = age_q[n] + 1'b1;
              if (age_d[n] == AGE_W'(LIFETIME)) begin
                act_d[n] = 1'b0;
              end
            end
          end
          if (spn_q == SPN_W'(SPAWN_TICKS - 1)) begin
            spn_d = '0;
            due   = 1'b1;
          end else begin
            spn_d = spn_q + 1'b1;
          end
        end
        // Descending scan so the lowest free slot wins.
        for (int n = NUM_MINES - 1; n >= 0; n--) begin
          if (!act_d[n]) begin
            free_ok  = 1'b1;
            free_idx = IDX_W'(n);
          end
        end
        unique case (st_q)
          SP_IDLE: begin
            if (due && free_ok) begin
              st_d  = SP_PICK;
              try_d = '0;
            end
          end
          SP_PICK: begin
            if (cand_ok) begin
              st_d = SP_IDLE;
              if (free_ok) begin
                x_d[free_idx]   = cx;
                y_d[free_idx]   = cy;
                age_d[free_idx] = '0;
                act_d[free_idx] = 1'b1;
              end
            end else if (try_q == TRY_W'(MAX_TRIES - 1)) begin
              st_d = SP_IDLE;
            end else begin
              try_d = try_q + 1'b1;
            end
          end
        endcase
      end
      game_status == GS_DIE: begin
      end
      default: begin
        for (int n = 0; n < NUM_MINES; n++) begin
          x_d[n]   = '0;
          y_d[n]   = '0;
          age_d[n] = '0;
        end
        act_d = '0;
        spn_d = '0;
        try_d = '0;
        st_d  = SP_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NUM_MINES; n++) begin
        x_q[n]   <= '0;
        y_q[n]   <= '0;
        age_q[n] <= '0;
      end
      act_q <= '0;
      spn_q <= '0;
      try_q <= '0;
      st_q  <= SP_IDLE;
      hit_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      age_q <= age_d;
      act_q <= act_d;
      spn_q <= spn_d;
      try_q <= try_d;
      st_q  <= st_d;
      hit_q <= hit_d;
    end
  end

  assign mine_x_0    = x_q[0];
  assign mine_x_1    = x_q[1];
  assign mine_x_2    = x_q[2];
  assign mine_x_3    = x_q[3];
  assign mine_y_0    = y_q[0];
  assign mine_y_1    = y_q[1];
  assign mine_y_2    = y_q[2];
  assign mine_y_3    = y_q[3];
  assign mine_active = act_q;
  assign mine_hit    = hit_q;

endmodule

// File: tb/tb_mine_scheduler.sv
// tb_mine_scheduler: directed stimulus with a per-cycle reference
// model of the mine rules, plus literal checks at key points.
module tb_mine_scheduler;

  localparam int          T_SPAWN = 8;
  localparam int          T_LIFE  = 40;
  localparam logic [15:0] T_SEED  = 16'hACE1;
  localparam int          T_XMAX  = 38;
  localparam int          T_YMAX  = 28;
  localparam int          T_TRIES = 16;

  logic       clk;
  logic       rst;
  logic [1:0] game_status;
  logic       tick;
  logic [5:0] head_x, head_y, apple_x;
  logic [4:0] apple_y;
  logic [5:0] mine_x_0, mine_x_1, mine_x_2, mine_x_3;
  logic [5:0] mine_y_0, mine_y_1, mine_y_2, mine_y_3;
  logic [3:0] mine_active;
  logic       mine_hit;

  logic [5:0] s_x0, s_x1, s_x2, s_x3;
  logic [5:0] s_y0, s_y1, s_y2, s_y3;
  logic [3:0] s_act;
  logic       s_hit;

  logic [5:0] dx [4];
  logic [5:0] dy [4];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  mine_scheduler u_dut (
    .clk(clk), .rst(rst), .game_status(game_status), .tick(tick),
    .head_x(head_x), .head_y(head_y),
    .apple_x(apple_x), .apple_y(apple_y),
    .mine_x_0(mine_x_0), .mine_x_1(mine_x_1),
    .mine_x_2(mine_x_2), .mine_x_3(mine_x_3),
    .mine_y_0(mine_y_0), .mine_y_1(mine_y_1),
    .mine_y_2(mine_y_2), .mine_y_3(mine_y_3),
    .mine_active(mine_active), .mine_hit(mine_hit)
  );

  // Only (1,1) is in range and it holds the apple: every spawn abandons.
  mine_scheduler #(.X_MAX(1), .Y_MAX(1)) u_small (
    .clk(clk), .rst(rst), .game_status(game_status), .tick(tick),
    .head_x(6'd2), .head_y(6'd2),
    .apple_x(6'd1), .apple_y(5'd1),
    .mine_x_0(s_x0), .mine_x_1(s_x1), .mine_x_2(s_x2), .mine_x_3(s_x3),
    .mine_y_0(s_y0), .mine_y_1(s_y1), .mine_y_2(s_y2), .mine_y_3(s_y3),
    .mine_active(s_act), .mine_hit(s_hit)
  );

  assign dx[0] = mine_x_0;
  assign dx[1] = mine_x_1;
  assign dx[2] = mine_x_2;
  assign dx[3] = mine_x_3;
  assign dy[0] = mine_y_0;
  assign dy[1] = mine_y_1;
  assign dy[2] = mine_y_2;
  assign dy[3] = mine_y_3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [15:0] mlfsr;
  logic [15:0] cur;
  int  mx [4];
  int  my [4];
  int  mage [4];
  bit  mon [4];
  bit  keep [4];
  int  mcnt, mtries, cx, cy;
  bit  mpick, mhit, due, placed;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic bit legal(input int x, input int y);
    bit ok;
    ok = (x >= 1) && (x <= T_XMAX) && (y >= 1) && (y <= T_YMAX);
    if (x == int'(apple_x) && y == int'(apple_y)) ok = 0;
    if (x == int'(head_x) && y == int'(head_y)) ok = 0;
    for (int n = 0; n < 4; n++)
      if (mon[n] && mx[n] == x && my[n] == y) ok = 0;
    return ok;
  endfunction

  task automatic model_clear();
    for (int n = 0; n < 4; n++) begin
      mx[n] = 0; my[n] = 0; mage[n] = 0; mon[n] = 0;
    end
    mcnt = 0; mpick = 0; mtries = 0; mhit = 0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mlfsr = T_SEED;
      model_clear();
    end else begin
      cur   = mlfsr;
      mlfsr = lfsr_step(mlfsr);
      mhit  = 0;
      if (game_status == 2'b10) begin
        keep = mon;
        due  = 0;
        if (tick) begin
          for (int n = 0; n < 4; n++) begin
            if (mon[n]) begin
              if (mx[n] == int'(head_x) && my[n] == int'(head_y)) begin
                keep[n] = 0;
                mhit    = 1;
              end
              mage[n]++;
              if (mage[n] == T_LIFE) keep[n] = 0;
            end
          end
          mcnt++;
          if (mcnt == T_SPAWN) begin
            mcnt = 0;
            due  = 1;
          end
        end
        if (mpick) begin
          cx = int'(cur[5:0]);
          cy = int'(cur[10:6]);
          if (legal(cx, cy)) begin
            mpick  = 0;
            placed = 0;
            for (int n = 0; n < 4; n++) begin
              if (!placed && !keep[n]) begin
                mx[n] = cx; my[n] = cy; mage[n] = 0;
                keep[n] = 1; placed = 1;
              end
            end
          end else begin
            mtries++;
            if (mtries == T_TRIES) mpick = 0;
          end
        end else if (due && !(keep[0] && keep[1] && keep[2] && keep[3])) begin
          mpick  = 1;
          mtries = 0;
        end
        mon = keep;
      end else if (game_status != 2'b11) begin
        model_clear();
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_active", 32'(mine_active),
          {28'd0, mon[3], mon[2], mon[1], mon[0]});
      chk("model_hit", 32'(mine_hit), 32'(mhit));
      for (int n = 0; n < 4; n++) begin
        if (mon[n]) begin
          chk($sformatf("model_x%0d", n), 32'(dx[n]), 32'(mx[n]));
          chk($sformatf("model_y%0d", n), 32'(dy[n]), 32'(my[n]));
        end
      end
      chk("small_active", 32'(s_act), 32'd0);
      chk("small_hit", 32'(s_hit), 32'd0);
      chk("small_xy", 32'(|{s_x0, s_x1, s_x2, s_x3,
                            s_y0, s_y1, s_y2, s_y3}), 32'd0);
    end
  end

  function automatic logic any_xy();
    return |{mine_x_0, mine_x_1, mine_x_2, mine_x_3,
             mine_y_0, mine_y_1, mine_y_2, mine_y_3};
  endfunction

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns one cycle after the tick was sampled.
  task automatic tick_pulse();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic ticks(input int cnt, input int gap);
    for (int i = 0; i < cnt; i++) begin
      tick_pulse();
      idle(gap - 1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    game_status = 2'b00;
    tick = 1'b0;
    head_x = 6'd5; head_y = 6'd5;
    apple_x = 6'd10; apple_y = 5'd10;
    @(negedge clk);
    chk_en = 1;
    idle(1);
    chk("rst_active", 32'(mine_active), 32'd0);
    chk("rst_hit", 32'(mine_hit), 32'd0);
    chk("rst_xy", 32'(any_xy()), 32'd0);

    // First spawn on tick 8 lands in slot 0.
    rst = 1'b0;
    game_status = 2'b10;
    idle(1);
    ticks(7, 20);
    chk("pre_spawn_active", 32'(mine_active), 32'd0);
    tick_pulse();
    idle(17);
    chk("spawn0_active", 32'(mine_active), 32'h1);
    chk("spawn0_x_legal",
        32'(mine_x_0 >= 6'd1 && mine_x_0 <= 6'd38), 32'd1);
    chk("spawn0_y_legal",
        32'(mine_y_0 >= 6'd1 && mine_y_0 <= 6'd28), 32'd1);
    chk("spawn0_not_apple",
        32'(mine_x_0 == 6'd10 && mine_y_0 == 6'd10), 32'd0);
    chk("spawn0_not_head",
        32'(mine_x_0 == 6'd5 && mine_y_0 == 6'd5), 32'd0);
    idle(2);

    // Ticks 9..47: slots fill at 16/24/32, tick 40 finds no room.
    for (int t = 9; t <= 47; t++) begin
      tick_pulse();
      idle(19);
      if (t == 32) chk("four_full", 32'(mine_active), 32'hF);
      if (t == 40) chk("full_skip", 32'(mine_active), 32'hF);
    end

    // Tick 48: slot 0 reaches 40 ticks, then refills as lowest free.
    tick_pulse();
    chk("expire0", 32'(mine_active), 32'hE);
    idle(19);
    chk("refill0", 32'(mine_active), 32'hF);

    // Tick 49: head on slot 1.
    head_x = 6'(mx[1]); head_y = 6'(my[1]);
    tick_pulse();
    chk("hit1_pulse", 32'(mine_hit), 32'd1);
    chk("hit1_clear", 32'(mine_active[1]), 32'd0);
    idle(1);
    chk("hit1_once", 32'(mine_hit), 32'd0);
    head_x = 6'd5; head_y = 6'd5;
    idle(18);

    // Ticks 50..63, then tick 64 hits slot 2 on its expiry tick.
    ticks(14, 20);
    head_x = 6'(mx[2]); head_y = 6'(my[2]);
    tick_pulse();
    chk("hitexp2_pulse", 32'(mine_hit), 32'd1);
    chk("hitexp2_clear", 32'(mine_active[2]), 32'd0);
    idle(1);
    chk("hitexp2_once", 32'(mine_hit), 32'd0);
    head_x = 6'd5; head_y = 6'd5;
    idle(18);

    // DIE: head on slot 3, ticks must do nothing.
    game_status = 2'b11;
    head_x = 6'(mx[3]); head_y = 6'(my[3]);
    idle(1);
    for (int i = 0; i < 10; i++) begin
      tick_pulse();
      chk("die_no_hit", 32'(mine_hit), 32'd0);
      idle(2);
    end
    chk("die_freeze3", 32'(mine_active[3]), 32'd1);
    head_x = 6'd5; head_y = 6'd5;
    game_status = 2'b10;
    idle(1);

    // Ticks 65..72; tick 72 opens a PICK, RESTART lands mid-PICK.
    ticks(7, 20);
    tick_pulse();
    game_status = 2'b00;
    idle(1);
    chk("restart_active", 32'(mine_active), 32'd0);
    chk("restart_xy", 32'(any_xy()), 32'd0);
    chk("restart_hit", 32'(mine_hit), 32'd0);
    game_status = 2'b10;
    idle(25);
    chk("restart_nopick", 32'(mine_active), 32'd0);

    // Closely spaced ticks so later ticks fall inside PICK.
    ticks(8, 4);
    idle(20);
    chk("respawn0", 32'(mine_active[0]), 32'd1);

    // Reset mid-game.
    rst = 1'b1;
    idle(1);
    chk("rst_mid_active", 32'(mine_active), 32'd0);
    chk("rst_mid_xy", 32'(any_xy()), 32'd0);
    chk("rst_mid_hit", 32'(mine_hit), 32'd0);
    rst = 1'b0;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mine_scheduler.md
# mine_scheduler

Owns the four mine slots drawn by the VGA interface renderer. It spawns mines at pseudo-random free grid cells on a fixed game-tick cadence and retires them after a fixed lifetime. It detects snake-head collisions and clears all mines on restart. It sits between the game-status controller and the display path, and drives the `mine_x_n` / `mine_y_n` / `mine_active` inputs of the renderer directly.

## Interface
- `SPAWN_TICKS`, 8: game ticks between spawn attempts (≥1)
- `LIFETIME`, 40: ticks a mine stays active (≥1)
- `LFSR_SEED`, 16'hACE1: LFSR reset value (non-zero)
- `X_MAX`, 38: largest legal mine column (playfield interior 1..X_MAX)
- `Y_MAX`, 28: largest legal mine row (1..Y_MAX)
- `MAX_TRIES`, 16: candidate attempts per spawn before abandoning

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `game_status`  in  2  00 RESTART, 01 START, 10 PLAY, 11 DIE
- `tick`  in  1  one-`clk` pulse per snake step
- `head_x`  in  6  snake head column
- `head_y`  in  6  snake head row
- `apple_x`  in  6  apple column
- `apple_y`  in  5  apple row
- `mine_x_0..mine_x_3`  out  6 each  mine columns
- `mine_y_0..mine_y_3`  out  6 each  mine rows
- `mine_active`  out  4  slot valid bits
- `mine_hit`  out  1  one-cycle pulse: head entered an active mine

## Operation
- **Reset / RESTART / START.** All outputs 0. Spawn counter 0, all age counters 0, FSM → IDLE. The LFSR reloads `LFSR_SEED` on `rst` only; RESTART and START do not reset it.
- **LFSR.** 16-bit Galois, taps x^16+x^14+x^13+x^11. It advances every `clk` when not in reset, in every state.
- **DIE.** Slots, counters and FSM freeze. Mines stay displayed. `tick` is ignored and `mine_hit` is held 0.
- **PLAY, on each `tick`, all in the same cycle:**
  - Hit check: for each active slot n, if (`head_x`,`head_y`) == (`mine_x_n`,`mine_y_n`), clear `mine_active[n]`. `mine_hit` = 1 in the next cycle if any slot matched.
  - Aging: each active slot's age increments. When age reaches `LIFETIME`, the slot clears. Hit and expiry on the same slot in the same tick: the slot clears and `mine_hit` still pulses.
  - Spawn counter increments. On reaching `SPAWN_TICKS` it wraps to 0. If any slot is free after this tick's clears, FSM IDLE → PICK with try counter 0. If all four slots are full, the attempt is skipped.
- **PICK.** One candidate per cycle: x = `lfsr[5:0]`, y = {1'b0, `lfsr[10:6]`}. The candidate is accepted when all of these hold:
  - 1 ≤ x ≤ `X_MAX` and 1 ≤ y ≤ `Y_MAX`
  - (x,y) ≠ apple (apple_y zero-extended)
  - (x,y) ≠ head
  - (x,y) ≠ every active mine
- **Accept.** Write the lowest-index free slot, set its active bit, zero its age, → IDLE.
- **Reject.** Increment the try counter. At `MAX_TRIES` rejects → IDLE with no spawn (abandoned).
- **`tick` during PICK.** Aging and hit checks still apply. The free slot is evaluated in the accept cycle, after that cycle's clears.
- **Leaving PLAY mid-PICK.** To RESTART/START: FSM → IDLE immediately. To DIE: PICK freezes.

## Timing
- All outputs are registered and reset to 0.
- `mine_hit` rises 1 cycle after the colliding `tick`, for exactly 1 cycle.
- Expiry or hit clear: `mine_active` bit falls 1 cycle after the `tick`.
- Spawn: the first PICK cycle is 1 cycle after the triggering `tick`. An accept on try k (0-based) makes the slot visible k+2 cycles after the `tick`.
- Worst case: spawn resolves within `MAX_TRIES`+1 cycles of the `tick`.
- A `game_status` change takes effect on the next edge.

## Structure
- Shared package `snake_pkg` holds:
  - game-status encodings RESTART/START/PLAY/DIE
  - NUM_MINES = 4
  - grid coordinate widths (column 6, row 6, apple row 5)
- Sub-module `mine_lfsr`: 16-bit Galois LFSR with seed parameter, `clk`/`rst`, 16-bit state output.
- Age counters are $clog2(`LIFETIME`+1) bits wide.

## Test plan
- **Reset then PLAY, default params.** 8 ticks → a mine appears at a legal cell (1..38, 1..28), not on apple/head, in slot 0 within 18 cycles of tick 8. `mine_active` = 4'b0001.
- **Lifetime.** Spawn a mine, then give 40 more ticks. `mine_active[0]` falls 1 cycle after the 40th tick following placement.
- **Collision.** Hold head on mine slot 1's cell and pulse `tick`. `mine_hit` = 1 for exactly one cycle and `mine_active[1]` = 0. Repeat with hit and expiry on the same tick: same result.
- **Full slots.** With 4 active mines, the spawn-threshold tick leaves the FSM in IDLE and the outputs unchanged. After one mine expires, the next threshold fills the freed lowest slot.
- **Rejection / abandon.** Force apple and head so that 16 consecutive candidates are illegal (use `X_MAX`=1, `Y_MAX`=1 with the apple at (1,1)). Spawn is abandoned, `mine_active` stays unchanged, FSM returns to IDLE 17 cycles after the tick.
- **Status transitions.**
  - RESTART mid-PICK clears all slots next cycle.
  - DIE freezes mines and suppresses `tick`/`mine_hit`.
  - `rst` asserted mid-game zeroes all outputs on the next edge.
